fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Drain stage directly downstream of the BRAM FIFO. Pops words using the FIFO's re/empty/q interface.
- Compensates for the fixed BRAM read latency and re-presents the data as a valid/ready stream for consumer logic (UART TX, SPI, etc.).
- Small internal skid buffer sustains 1 word/cycle with no data loss under backpressure.
- Supports a synchronous flush that discards buffered and in-flight words.

Parameters:
- DATA_WIDTH, 8, stream and FIFO word width (1..16).
- RD_LATENCY, 1, cycles from fifo_re high to fifo_q valid (1 or 2).
- BUF_DEPTH, RD_LATENCY+1, skid buffer entries; must be >= RD_LATENCY+1.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- fifo_empty  in  1  FIFO empty flag
- fifo_re  out  1  FIFO pop strobe, one word per high cycle
- fifo_q  in  DATA_WIDTH  FIFO read data, valid RD_LATENCY cycles after fifo_re
- flush  in  1  single-cycle or level discard request
- m_valid  out  1  output word available
- m_ready  in  1  consumer accepts word
- m_data  out  DATA_WIDTH  output word
- busy  out  1  high while in FLUSH state or any read in flight

Behaviour:
- Reset (rst_n=0 at clk edge):
  - Outputs: fifo_re=0, m_valid=0, m_data=0, busy=0.
  - Internal state: occupancy=0, in-flight shift register cleared, state=RUN.
- Reset mid-operation: in-flight words are lost. The FIFO pointer has already advanced; this is accepted behaviour.
- Transfer rule: a transfer occurs on a cycle with m_valid & m_ready.
- Output stability: while m_valid=1 and m_ready=0, m_data is held stable. m_valid never drops without a transfer, except on flush or reset.
- In-flight tracking: a RD_LATENCY-deep shift register of valid bits follows each fifo_re. When a bit emerges, fifo_q is written at the buffer tail.
- Credit rule: fifo_re = state==RUN & ~flush & ~fifo_empty & (occ + inflight - pop) < BUF_DEPTH, where pop = m_valid & m_ready (same-cycle pop credit).
- Guarantees: the buffer never overflows, and throughput is 1 word/cycle when m_ready is held high.
- Occupancy update: occ' = occ + land - pop. Width is clog2(BUF_DEPTH+1).
- Buffer structure: circular, with head/tail pointers wrapping modulo BUF_DEPTH; non-power-of-2 depth is handled by explicit compare-and-reset.
- Latency: first word reaches m_valid RD_LATENCY+1 cycles after fifo_empty falls (1 cycle for the re decision, then RD_LATENCY).
- State machine:
  - RUN:
    - On flush=1: clear buffer (occ=0, head=tail), force m_valid=0 next cycle, latch discard count = inflight bits.
    - If inflight != 0, go to FLUSH; else remain in RUN.
  - FLUSH:
    - No fifo_re.
    - Landing words are dropped.
    - Exit to RUN when the in-flight register is empty.
    - flush held high keeps the state in FLUSH (RUN with re blocked if nothing in flight).
- Simultaneous events:
  - flush with pop: the pop is honoured (consumer saw valid), then the buffer is cleared.
  - flush with land: the landed word is dropped.
  - land with pop on a full buffer: legal; occ unchanged.
- Empty FIFO: no re is issued and m_valid falls after the last buffered word transfers.
- fifo_empty glitching high between re cycles is tolerated; re is gated each cycle.

Optional Feature:
- Macro: FIFO_STREAM_READER_STATS_EN.
- With the macro defined, the block adds these output ports:
  - stat_words[31:0]: count of transfers, wraps at 2^32.
  - stat_stall[15:0]: cycles with m_valid & ~m_ready, saturates at 0xFFFF.
  - Both counters clear on reset and are unaffected by flush.
- Without the macro: neither the ports nor the counters exist, and the rest of the behaviour is identical.

Decomposition:
- Shared package fifo_rd_pkg holds:
  - state encoding constants ST_RUN=0, ST_FLUSH=1
  - default DATA_WIDTH and RD_LATENCY
  - the clog2 function
- One natural sub-module, fifo_rd_skid: the circular buffer with push/pop/clear, occupancy output and head data output.
- Top level holds the credit logic, in-flight shift register, FSM and stats.

Test Plan:
- Streaming: preload 20 words 0x01..0x14, m_ready=1 -> fifo_re high for 20 consecutive cycles; m_data 0x01..0x14 in order, one per cycle; first m_valid 2 cycles after first re (RD_LATENCY=1).
- Backpressure: 10 words, m_ready=0 for cycles 3..12 -> at most BUF_DEPTH words buffered; re stops; no loss or duplication; m_data held constant while stalled.
- Flush: flush pulsed the cycle after re, with 1 in flight -> state FLUSH for 1 cycle; landed word dropped; m_valid=0; busy=1 then 0; the next words resume cleanly.
- Empty: fifo_empty toggles every cycle, m_ready random -> output sequence equals FIFO order; re is never asserted while fifo_empty=1.
- Reset mid-stream: rst_n=0 for 1 cycle with the buffer full -> next cycle m_valid=0, fifo_re=0, occ=0; the stream resumes with the word following those lost.
- Stats (macro on): 100 transfers with 7 stall cycles -> stat_words=100, stat_stall=7; after reset both 0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types, defaults and helpers for the FIFO stream reader.
//   ST_RUN / ST_FLUSH : reader state encoding
//   DEF_DATA_WIDTH    : default stream/FIFO word width
//   DEF_RD_LATENCY    : default BRAM read latency (fifo_re -> fifo_q)
//   clog2()           : ceiling log2 for elaboration-time widths
package fifo_rd_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_RD_LATENCY = 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned p = 1; p < value; p = p << 1) res++;
    return res;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: circular skid buffer with push/pop/clear.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_i      : empty the buffer (wins over push/pop)
//   push_i     : write din_i at the tail
//   pop_i      : advance the head
//   dout_o     : word at the head
//   occ_o      : number of stored words
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_RD_LATENCY + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [DATA_WIDTH-1:0]         din_i,
  output logic [DATA_WIDTH-1:0]         dout_o,
  output logic [clog2(DEPTH + 1)-1:0]   occ_o
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned OCC_W = clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [OCC_W-1:0]      occ_q, occ_d;

  // Depth need not be a power of two, so wrap by compare-and-reset.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy next state.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clr_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push_i) tail_d = ptr_inc(tail_q);
      if (pop_i)  head_d = ptr_inc(head_q);
      occ_d = occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      if (push_i && !clr_i) mem_q[tail_q] <= din_i;
    end
  end

  assign dout_o = mem_q[head_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a BRAM FIFO (re/empty/q) into a valid/ready stream,
// absorbing the fixed read latency with a credit-controlled skid buffer.
//   clk, rst_n         : clock, synchronous active-low reset
//   fifo_empty/re/q    : FIFO pop interface (q valid RD_LATENCY cycles after re)
//   flush              : discard buffered and in-flight words
//   m_valid/ready/data : output stream
//   busy               : FLUSH state or any read in flight
// Optional: FIFO_STREAM_READER_STATS_EN adds stat_words (transfers, wrapping)
// and stat_stall (m_valid & ~m_ready cycles, saturating).
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY,
  parameter int unsigned BUF_DEPTH  = RD_LATENCY + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [15:0]           stat_stall
`endif
);

  localparam int unsigned OCC_W = clog2(BUF_DEPTH + 1);
  localparam int unsigned INF_W = clog2(RD_LATENCY + 1);
  localparam int unsigned SUM_W = OCC_W + 1;

  state_e                state_q, state_d;
  logic [RD_LATENCY-1:0] sr_q, sr_d;
  logic                  busy_q, busy_d;
  logic [OCC_W-1:0]      occ;
  logic [INF_W-1:0]      inflight;
  logic                  pop, land, push, re_c, credit_ok;

  // Count of reads issued but not yet landed.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) inflight = inflight + INF_W'(sr_q[i]);
  end

  assign pop  = m_valid & m_ready;
  assign land = sr_q[RD_LATENCY-1];

  // occ + inflight - pop < BUF_DEPTH, rearranged to avoid underflow.
  assign credit_ok = (SUM_W'(occ) + SUM_W'(inflight)) < (SUM_W'(BUF_DEPTH) + SUM_W'(pop));

  // Gated every cycle so an empty flag glitching high never pops.
  assign re_c    = rst_n & (state_q == ST_RUN) & ~flush & ~fifo_empty & credit_ok;
  assign fifo_re = re_c;

  // Words landing during a flush or in FLUSH belong to the discarded stream.
  assign push = land & (state_q == ST_RUN) & ~flush;

  assign m_valid = (occ != '0);

  // Next state for FSM, in-flight tracker and busy.
  always_comb begin
    state_d = state_q;
    sr_d    = (sr_q << 1) | RD_LATENCY'(re_c);
    case (state_q)
      ST_RUN:   if (flush && inflight != '0) state_d = ST_FLUSH;
      ST_FLUSH: if (!flush && sr_q == '0)    state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    busy_d = (state_d == ST_FLUSH) | (sr_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      sr_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

  // A pop in the flush cycle is honoured; the clear then empties the buffer.
  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (flush),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (fifo_q),
    .dout_o (m_data),
    .occ_o  (occ)
  );

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] words_q;
  logic [15:0] stall_q;

  // Transfer and stall counters; flush does not touch them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (pop) words_q <= words_q + 32'd1;
      if (m_valid && !m_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader (defaults: 8-bit, RD_LATENCY=1, BUF_DEPTH=2).
// A BRAM FIFO model feeds the DUT; expected words go into a scoreboard queue
// that an independent monitor drains on every transfer.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty;
  logic       fifo_re;
  logic [7:0] fifo_q = 8'h00;
  logic       flush = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       busy;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] stat_words;
  logic [15:0] stat_stall;
`endif

  logic [7:0]  fmem [0:1023];
  int unsigned wr_cnt = 0;
  int unsigned rd_cnt = 0;
  logic        gate_empty = 1'b0;
  logic [7:0]  exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  fifo_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .fifo_q     (fifo_q),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_stall (stat_stall)
`endif
  );

  // BRAM FIFO model, one cycle read latency.
  assign fifo_empty = (wr_cnt == rd_cnt) || gate_empty;
  always @(posedge clk) begin
    if (fifo_re) begin
      fifo_q <= fmem[10'(rd_cnt)];
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Put n words into the FIFO; the first 'skip' are expected to be lost.
  task automatic load(input int unsigned n, input logic [7:0] first, input int unsigned skip);
    for (int unsigned i = 0; i < n; i++) begin
      fmem[10'(wr_cnt + i)] = first + 8'(i);
      if (i >= skip) exp_q.push_back(first + 8'(i));
    end
    wr_cnt = wr_cnt + n;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(nm, 32'(exp_q.size()), 32'd0);
    repeat (4) step();
  endtask

  // Scoreboard monitor: order, no loss/duplication, stall stability, re gating.
  initial begin
    logic [7:0] want;
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (fifo_re) chk("re_while_empty", 32'(fifo_empty), 32'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          want = exp_q.pop_front();
          chk("stream_data", 32'(m_data), 32'(want));
        end
      end
      if (prev_stall) begin
        chk("stall_valid_held", 32'(m_valid), 32'd1);
        chk("stall_data_held", 32'(m_data), 32'(prev_data));
      end
      prev_stall = rst_n && m_valid && !m_ready && !flush;
      prev_data  = m_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_re", 32'(fifo_re), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();

    // Streaming: 20 words back to back.
    m_ready = 1'b1;
    load(20, 8'h01, 0);
    for (int k = 0; k < 23; k++) begin
      @(negedge clk);
      chk("stream_re", 32'(fifo_re), 32'(k < 20));
      chk("stream_valid", 32'(m_valid), 32'(k >= 2 && k < 22));
      step();
    end
    drain("stream_drain");

    // Backpressure: consumer stalls for cycles 3..12.
    load(10, 8'h21, 0);
    for (int k = 0; k < 24; k++) begin
      m_ready = !(k >= 3 && k <= 12);
      @(negedge clk);
      chk("bp_re", 32'(fifo_re), 32'(k < 3 || (k >= 13 && k < 20)));
      chk("bp_valid", 32'(m_valid), 32'(k >= 2 && k <= 21));
      if (k == 8) chk("bp_head", 32'(m_data), 32'h22);
      step();
    end
    m_ready = 1'b1;
    drain("bp_drain");

    // Flush one cycle after the first re; the in-flight word is dropped.
    load(5, 8'h31, 1);
    for (int k = 0; k < 10; k++) begin
      flush = (k == 1);
      @(negedge clk);
      chk("fl_re", 32'(fifo_re), 32'(k == 0 || (k >= 3 && k <= 6)));
      chk("fl_valid", 32'(m_valid), 32'(k >= 5 && k <= 8));
      chk("fl_busy", 32'(busy), 32'(k == 1 || k == 2 || (k >= 4 && k <= 7)));
      step();
    end
    flush = 1'b0;
    drain("fl_drain");

    // Empty flag toggling every cycle with a random consumer.
    load(16, 8'h41, 0);
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      gate_empty = (c % 2 == 0);
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    gate_empty = 1'b0;
    m_ready = 1'b1;
    chk("toggle_drain", 32'(exp_q.size()), 32'd0);
    repeat (4) step();

    // Reset with the buffer full: the two buffered words are lost.
    m_ready = 1'b0;
    load(8, 8'h61, 2);
    for (int k = 0; k < 6; k++) begin
      rst_n = (k != 4);
      m_ready = (k >= 5);
      @(negedge clk);
      chk("rs_re", 32'(fifo_re), 32'(k <= 1 || k == 5));
      chk("rs_valid", 32'(m_valid), 32'(k >= 2 && k <= 4));
      chk("rs_busy", 32'(busy), 32'(k == 1 || k == 2));
      if (k == 2 || k == 4) chk("rs_head", 32'(m_data), 32'h61);
      if (k == 5) chk("rs_data_cleared", 32'(m_data), 32'd0);
      step();
    end
    rst_n = 1'b1;
    m_ready = 1'b1;
    drain("rs_drain");

`ifdef FIFO_STREAM_READER_STATS_EN
    // Statistics: 100 transfers with exactly 7 stall cycles.
    m_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("st_words_rst", stat_words, 32'd0);
    chk("st_stall_rst", 32'(stat_stall), 32'd0);
    step();
    load(100, 8'h01, 0);
    for (int k = 0; k < 9; k++) begin
      m_ready = !(k >= 2 && k <= 8);
      step();
    end
    m_ready = 1'b1;
    drain("st_drain");
    @(negedge clk);
    chk("st_words", stat_words, 32'd100);
    chk("st_stall", 32'(stat_stall), 32'd7);
    step();
    m_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("st_words_rst2", stat_words, 32'd0);
    chk("st_stall_rst2", 32'(stat_stall), 32'd0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
